// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer: rank encoding, deck size,
// FSM state and requester identities, plus small rank helpers.
package card_pkg;

    typedef logic [3:0] rank_t;

    localparam rank_t RANK_MIN  = 4'd1;
    localparam rank_t RANK_MAX  = 4'd13;
    localparam int    NUM_RANKS = 13;
    localparam int    DECK_SIZE = 52;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        SCAN  = 2'd2,
        GRANT = 2'd3
    } dealer_state_t;

    typedef enum logic {
        PLAYER = 1'b0,
        DEALER = 1'b1
    } requester_t;

    function automatic logic rank_valid(rank_t r);
        return (r >= RANK_MIN) && (r <= RANK_MAX);
    endfunction

    // Scan order wraps K back to A.
    function automatic rank_t next_rank(rank_t r);
        return (r == RANK_MAX) ? RANK_MIN : r + 4'd1;
    endfunction

endpackage

// File: rtl/card_if.sv
// Draw request / grant handshake between the game FSMs and the card dealer,
// together with the dealt card and deck status seen by both game FSMs.
interface card_if;
    import card_pkg::*;

    logic       req_player;
    logic       req_dealer;
    logic       grant_player;
    logic       grant_dealer;
    rank_t      card;
    logic [5:0] cards_left;
    logic       deck_empty;

    modport master (
        output req_player, req_dealer,
        input  grant_player, grant_dealer, card, cards_left, deck_empty
    );

    modport slave (
        input  req_player, req_dealer,
        output grant_player, grant_dealer, card, cards_left, deck_empty
    );

endinterface

// File: rtl/deck_tracker.sv
// Per-rank dealt counters for one deck: availability query for a single rank,
// increment on deal, bulk clear on shuffle, and the remaining-card count.
module deck_tracker
    import card_pkg::*;
#(
    parameter int MAX_PER_RANK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    input  rank_t      query_rank,
    output logic       avail,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    logic [NUM_RANKS-1:0] rank_sel;
    logic [NUM_RANKS-1:0] rank_open;
    logic [5:0]           cards_left_reg;
    logic                 deck_empty_reg;

    // Each rank owns its counter so a shuffle clears all of them in one cycle.
    generate
        for (genvar gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
            logic [2:0] count_reg;

            assign rank_sel[gi]  = (query_rank == rank_t'(gi + 1));
            assign rank_open[gi] = (count_reg < 3'(MAX_PER_RANK));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (inc && rank_sel[gi] && rank_open[gi]) begin
                    count_reg <= count_reg + 3'd1;
                end
            end
        end
    endgenerate

    // Out-of-range ranks select nothing, so they are never available.
    assign avail = |(rank_sel & rank_open);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cards_left_reg <= 6'(DECK_SIZE);
            deck_empty_reg <= 1'b0;
        end else if (clear) begin
            cards_left_reg <= 6'(DECK_SIZE);
            deck_empty_reg <= 1'b0;
        end else if (inc && avail) begin
            cards_left_reg <= cards_left_reg - 6'd1;
            deck_empty_reg <= (cards_left_reg == 6'd1);
        end
    end

    assign cards_left = cards_left_reg;
    assign deck_empty = deck_empty_reg;

endmodule

// File: rtl/card_dealer.sv
// Single-deck card dispenser: round-robin arbitration between player and dealer,
// LFSR rank sampling with rejection of exhausted ranks, and a bounded fallback scan.
module card_dealer
    import card_pkg::*;
#(
    parameter int MAX_PER_RANK = 4,
    parameter int RETRY_LIMIT  = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  rank_t rnd,
    input  logic  shuffle,
    card_if.slave bus,
    output logic  busy
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DRAW  = DRAW;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_GRANT = GRANT;

    localparam int RW = (RETRY_LIMIT > 1) ? $clog2(RETRY_LIMIT) : 1;

    logic [1:0]    state_reg,  state_next;
    requester_t    winner_reg, winner_next;
    requester_t    last_reg,   last_next;
    logic [RW-1:0] retry_reg,  retry_next;
    rank_t         scan_reg,   scan_next;
    rank_t         card_reg,   card_next;

    logic       deal;
    logic       avail;
    rank_t      query_rank;
    logic [5:0] cards_left_w;
    logic       deck_empty_w;

    // DRAW checks the live LFSR value; SCAN walks its own rank pointer.
    assign query_rank = (state_reg == ST_SCAN) ? scan_reg : rnd;

    deck_tracker #(
        .MAX_PER_RANK (MAX_PER_RANK)
    ) u_deck (
        .clk        (clk),
        .rst        (rst),
        .clear      (shuffle),
        .inc        (deal),
        .query_rank (query_rank),
        .avail      (avail),
        .cards_left (cards_left_w),
        .deck_empty (deck_empty_w)
    );

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        last_next   = last_reg;
        retry_next  = retry_reg;
        scan_next   = scan_reg;
        card_next   = card_reg;
        deal        = 1'b0;

        if (shuffle) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if ((bus.req_player || bus.req_dealer) && !deck_empty_w) begin
                        state_next = ST_DRAW;
                        retry_next = '0;
                        if (bus.req_player && bus.req_dealer) begin
                            winner_next = (last_reg == DEALER) ? PLAYER : DEALER;
                        end else begin
                            winner_next = bus.req_player ? PLAYER : DEALER;
                        end
                    end
                end
                ST_DRAW: begin
                    if (avail) begin
                        deal       = 1'b1;
                        card_next  = query_rank;
                        state_next = ST_GRANT;
                    end else if (retry_reg == RW'(RETRY_LIMIT - 1)) begin
                        state_next = ST_SCAN;
                        scan_next  = rank_valid(rnd) ? rnd : RANK_MIN;
                    end else begin
                        retry_next = retry_reg + RW'(1);
                    end
                end
                ST_SCAN: begin
                    // cards_left > 0 here, so some rank is free within 13 steps.
                    if (avail) begin
                        deal       = 1'b1;
                        card_next  = query_rank;
                        state_next = ST_GRANT;
                    end else begin
                        scan_next = next_rank(scan_reg);
                    end
                end
                ST_GRANT: begin
                    last_next  = winner_reg;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            winner_reg <= PLAYER;
            last_reg   <= DEALER;
            retry_reg  <= '0;
            scan_reg   <= RANK_MIN;
            card_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
            last_reg   <= last_next;
            retry_reg  <= retry_next;
            scan_reg   <= scan_next;
            card_reg   <= card_next;
        end
    end

    // A shuffle landing on the GRANT cycle voids the card, so the pulse is masked.
    assign bus.grant_player = (state_reg == ST_GRANT) && (winner_reg == PLAYER) && !shuffle;
    assign bus.grant_dealer = (state_reg == ST_GRANT) && (winner_reg == DEALER) && !shuffle;
    assign bus.card         = card_reg;
    assign bus.cards_left   = cards_left_w;
    assign bus.deck_empty   = deck_empty_w;
    assign busy             = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a transaction-level deck model predicts
// every grant cycle and card from the pre-generated rank stream; outputs checked each cycle.
module tb_card_dealer;
    import card_pkg::*;

    localparam int SEQ_LEN = 16384;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  shuffle = 1'b0;
    rank_t rnd = '0;
    logic  busy;

    card_if bus();

    card_dealer #(
        .MAX_PER_RANK (4),
        .RETRY_LIMIT  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rnd     (rnd),
        .shuffle (shuffle),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int gcyc = 0;
    int phase_base = 0;

    int rnd_seq [SEQ_LEN];
    bit shuf_seq[SEQ_LEN];

    // Deck model: ranks dealt per value, cards remaining, last card, round-robin memory.
    int cnt[1:13];
    int m_left, m_card, m_last;     // m_last: 0 = player, 1 = dealer
    bit pend;
    int pend_who, pend_card, pend_gcyc;
    bit shuf_prev;

    bit exp_gp, exp_gd, exp_busy, exp_empty;
    int exp_card, exp_left;
    bit chk_en = 1'b0;

    int req_mode;                   // 0 = fixed levels, 1 = random requesters
    bit fix_p, fix_d;
    bit gp_prev, gd_prev;

    int log_cyc[$], log_who[$], log_card[$], log_left[$];

    int exp_c5[5];
    int exp_w5[5];
    int exp_k5[5];
    int rank_hist[1:13];

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, gcyc, act, exp);
        end
    endtask

    function automatic int lg(int which, int i);
        case (which)
            0: return (log_cyc.size()  > i) ? log_cyc[i]  : -1;
            1: return (log_who.size()  > i) ? log_who[i]  : -1;
            2: return (log_card.size() > i) ? log_card[i] : -1;
            default: return (log_left.size() > i) ? log_left[i] : -1;
        endcase
    endfunction

    function automatic void model_init();
        for (int r = 1; r <= 13; r++) cnt[r] = 0;
        m_left = 52; m_card = 0; m_last = 1;
        pend = 1'b0; shuf_prev = 1'b0; gp_prev = 1'b0; gd_prev = 1'b0;
    endfunction

    // Given a draw latched at cycle t, find when and what the dealer must hand out.
    function automatic void plan(int t);
        int  r;
        bit  done;
        done = 1'b0;
        r = 0;
        for (int j = 0; j < 16 && !done; j++) begin
            r = rnd_seq[t + 1 + j];
            if (r >= 1 && r <= 13 && cnt[r] < 4) begin
                pend_gcyc = t + 2 + j; pend_card = r; done = 1'b1;
            end
        end
        if (!done) begin
            int s;
            s = (r >= 1 && r <= 13) ? r : 1;
            for (int k = 0; k < 13 && !done; k++) begin
                int rk;
                rk = ((s - 1 + k) % 13) + 1;
                if (cnt[rk] < 4) begin
                    pend_gcyc = t + 18 + k; pend_card = rk; done = 1'b1;
                end
            end
        end
    endfunction

    task automatic fill_const(int v);
        for (int i = gcyc; i < gcyc + 1024 && i < SEQ_LEN; i++) begin
            rnd_seq[i] = v; shuf_seq[i] = 1'b0;
        end
    endtask

    // Biased toward a few ranks so exhaustion and the fallback scan happen often.
    task automatic fill_rand(int n, int shuf_one_in);
        for (int i = gcyc; i < gcyc + n + 64 && i < SEQ_LEN; i++) begin
            rnd_seq[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 7));
            shuf_seq[i] = (shuf_one_in > 0) && ($urandom_range(0, shuf_one_in - 1) == 0);
        end
    endtask

    task automatic begin_phase();
        phase_base = gcyc;
        log_cyc.delete(); log_who.delete(); log_card.delete(); log_left.delete();
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_grant_player"}, bus.grant_player, 0);
        chk({tag, "_grant_dealer"}, bus.grant_dealer, 0);
        chk({tag, "_busy"},         busy, 0);
        chk({tag, "_card"},         bus.card, 0);
        chk({tag, "_cards_left"},   bus.cards_left, 52);
        chk({tag, "_deck_empty"},   bus.deck_empty, 0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1; bus.req_player = 1'b0; bus.req_dealer = 1'b0; shuffle = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_init();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            rnd     = rank_t'(rnd_seq[gcyc]);
            shuffle = shuf_seq[gcyc];
            if (req_mode == 0) begin
                bus.req_player = fix_p; bus.req_dealer = fix_d;
            end else begin
                if (gp_prev)              bus.req_player = ($urandom_range(0, 1) == 1);
                else if (!bus.req_player) bus.req_player = ($urandom_range(0, 3) == 0);
                if (gd_prev)              bus.req_dealer = ($urandom_range(0, 1) == 1);
                else if (!bus.req_dealer) bus.req_dealer = ($urandom_range(0, 3) == 0);
            end

            if (shuf_prev) begin
                for (int r = 1; r <= 13; r++) cnt[r] = 0;
                m_left = 52; pend = 1'b0;
            end else if (pend && gcyc == pend_gcyc) begin
                cnt[pend_card]++; m_left--; m_card = pend_card;
            end
            shuf_prev = 1'b0;

            exp_busy  = pend;
            exp_gp    = pend && (gcyc == pend_gcyc) && (pend_who == 0) && !shuffle;
            exp_gd    = pend && (gcyc == pend_gcyc) && (pend_who == 1) && !shuffle;
            exp_card  = m_card;
            exp_left  = m_left;
            exp_empty = (m_left == 0);
            chk_en    = 1'b1;

            @(negedge clk);
            gp_prev = exp_gp; gd_prev = exp_gd;
            if (shuffle) begin
                shuf_prev = 1'b1;
            end else if (pend && gcyc == pend_gcyc) begin
                m_last = pend_who; pend = 1'b0;
            end else if (!pend && m_left > 0 && (bus.req_player || bus.req_dealer)) begin
                pend = 1'b1;
                if (bus.req_player && bus.req_dealer) pend_who = (m_last == 1) ? 0 : 1;
                else                                  pend_who = bus.req_player ? 0 : 1;
                plan(gcyc);
            end
            @(posedge clk); #1;
            gcyc++;
        end
        chk_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant_player", bus.grant_player, exp_gp);
            chk("grant_dealer", bus.grant_dealer, exp_gd);
            chk("busy",         busy,             exp_busy);
            chk("card",         bus.card,         exp_card);
            chk("cards_left",   bus.cards_left,   exp_left);
            chk("deck_empty",   bus.deck_empty,   exp_empty);
            if (bus.grant_player || bus.grant_dealer) begin
                log_cyc.push_back(gcyc - phase_base);
                log_who.push_back(bus.grant_dealer ? 1 : 0);
                log_card.push_back(int'(bus.card));
                log_left.push_back(int'(bus.cards_left));
                $display("grant cyc=%0d who=%s card=%0d left=%0d", gcyc - phase_base,
                         bus.grant_dealer ? "dealer" : "player", bus.card, bus.cards_left);
            end
        end
    end

    initial begin
        bus.req_player = 1'b0; bus.req_dealer = 1'b0;
        req_mode = 0; fix_p = 1'b0; fix_d = 1'b0;
        exp_c5 = '{2, 5, 8, 11, 31};
        exp_w5 = '{0, 1, 0, 1, 0};
        exp_k5 = '{7, 7, 7, 7, 8};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        model_init();

        // Single player request, immediate hit on rank 5.
        begin_phase(); fill_const(5); fix_p = 1'b1; fix_d = 1'b0;
        run(3);
        chk("t1_grants",     log_cyc.size(), 1);
        chk("t1_grant_cyc",  lg(0, 0), 2);
        chk("t1_who",        lg(1, 0), 0);
        chk("t1_card",       lg(2, 0), 5);
        chk("t1_cards_left", lg(3, 0), 51);

        // Both requesting on constant 7: alternation, exhaustion, then scan to 8.
        do_reset(); begin_phase(); fill_const(7); fix_p = 1'b1; fix_d = 1'b1;
        run(32);
        chk("t2_grants", log_cyc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_grant_cyc", lg(0, i), exp_c5[i]);
            chk("t2_who",       lg(1, i), exp_w5[i]);
            chk("t2_card",      lg(2, i), exp_k5[i]);
        end

        // Scan wrap: rank 13 exhausted and stuck -> ace.
        do_reset(); begin_phase(); fill_const(13); fix_p = 1'b1; fix_d = 1'b0;
        run(32);
        chk("t3_grants",    log_cyc.size(), 5);
        chk("t3_wrap_cyc",  lg(0, 4), 31);
        chk("t3_wrap_card", lg(2, 4), 1);

        // Invalid LFSR values never produce a card.
        do_reset(); begin_phase(); fill_const(4);
        rnd_seq[gcyc] = 0; rnd_seq[gcyc + 1] = 0; rnd_seq[gcyc + 2] = 15; rnd_seq[gcyc + 3] = 0;
        run(6);
        chk("t4_grants",    log_cyc.size(), 1);
        chk("t4_grant_cyc", lg(0, 0), 5);
        chk("t4_card",      lg(2, 0), 4);

        // Deal the whole deck, stay empty, then shuffle releases the pending request.
        do_reset(); begin_phase(); fill_rand(2600, 0); fix_p = 1'b1; fix_d = 1'b0;
        run(2600);
        chk("t5_grants",     log_cyc.size(), 52);
        chk("t5_cards_left", bus.cards_left, 0);
        chk("t5_deck_empty", bus.deck_empty, 1);
        for (int r = 1; r <= 13; r++) rank_hist[r] = 0;
        foreach (log_card[i]) if (log_card[i] >= 1 && log_card[i] <= 13) rank_hist[log_card[i]]++;
        for (int r = 1; r <= 13; r++) chk("t5_rank_copies", rank_hist[r], 4);
        begin_phase(); fill_rand(60, 0); shuf_seq[gcyc] = 1'b1;
        run(1);
        chk("t5_left_after_shuffle",  bus.cards_left, 52);
        chk("t5_empty_after_shuffle", bus.deck_empty, 0);
        run(40);
        chk("t5_pending_granted", int'(log_cyc.size() > 0), 1);

        // Shuffle during DRAW abandons the draw.
        do_reset(); begin_phase(); fill_const(5);
        rnd_seq[gcyc + 1] = 0; rnd_seq[gcyc + 2] = 0; shuf_seq[gcyc + 2] = 1'b1;
        run(6);
        chk("t6a_grants",     log_cyc.size(), 1);
        chk("t6a_grant_cyc",  lg(0, 0), 5);
        chk("t6a_cards_left", lg(3, 0), 51);

        // Shuffle on the GRANT cycle suppresses the grant and voids the card.
        do_reset(); begin_phase(); fill_const(5); shuf_seq[gcyc + 2] = 1'b1;
        run(6);
        chk("t6b_grants",     log_cyc.size(), 1);
        chk("t6b_grant_cyc",  lg(0, 0), 5);
        chk("t6b_cards_left", lg(3, 0), 51);

        // Asynchronous reset while scanning.
        do_reset(); begin_phase(); fill_const(7); fix_p = 1'b1; fix_d = 1'b0;
        run(30);
        chk("t6c_busy_in_scan", busy, 1);
        chk("t6c_grants",       log_cyc.size(), 4);
        rst = 1'b1;
        #1;
        check_reset_vals("t6c_async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_init();

        // Randomised traffic: both requesters, frequent then rare shuffles.
        do_reset(); begin_phase(); req_mode = 1; fill_rand(3000, 100);
        run(3000);
        do_reset(); begin_phase(); fill_rand(3000, 1500);
        run(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
